param_gcd_engine: RTL

PARAM_GCD_ENGINE -- requirements
Module: param_gcd_engine

---
 rtl/gcd_pkg.sv | 18 +
 rtl/gcd_step.sv | 46 ++++
 rtl/param_gcd_engine.sv | 130 +++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared types and elaboration helpers for the binary GCD engine.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Ceiling log2 for parameter-derived widths; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/gcd_step.sv
// Single Stein (binary GCD) step: one reduction of (ra, rb, k) per evaluation.
module gcd_step
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned KW    = clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] ra,
  input  logic [WIDTH-1:0] rb,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] ra_next_c,
  output logic [WIDTH-1:0] rb_next_c,
  output logic [KW-1:0]    k_next_c,
  output logic             finish_c,
  output logic [WIDTH-1:0] result_c
);

  // Priority order matters: zero checks first, then common factors of two.
  always_comb begin
    ra_next_c = ra;
    rb_next_c = rb;
    k_next_c  = k;
    finish_c  = 1'b0;
    result_c  = '0;
    if (ra == '0) begin
      finish_c = 1'b1;
      result_c = rb << k;
    end else if (rb == '0) begin
      finish_c = 1'b1;
      result_c = ra << k;
    end else if (!ra[0] && !rb[0]) begin
      ra_next_c = ra >> 1;
      rb_next_c = rb >> 1;
      k_next_c  = k + KW'(1);
    end else if (!ra[0]) begin
      ra_next_c = ra >> 1;
    end else if (!rb[0]) begin
      rb_next_c = rb >> 1;
    end else if (ra >= rb) begin
      ra_next_c = (ra - rb) >> 1;
    end else begin
      rb_next_c = (rb - ra) >> 1;
    end
  end

endmodule

// File: rtl/param_gcd_engine.sv
// Iterative binary GCD engine: one Stein step per clock, registered results.
module param_gcd_engine
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned CW   = clog2(2 * WIDTH + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] gcd,
  output logic [CW-1:0]    cycles,
  output logic             zero_in
);

  localparam int unsigned KW      = clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(2 * WIDTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d, res_q, res_d, gcd_q, gcd_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CW-1:0]    cnt_q, cnt_d, cycles_q, cycles_d;
  logic             zlat_q, zlat_d, busy_q, busy_d, done_q, done_d;
  logic             zero_in_q, zero_in_d;

  logic [WIDTH-1:0] step_ra, step_rb, step_res;
  logic [KW-1:0]    step_k;
  logic             step_fin;

  gcd_step #(
    .WIDTH(WIDTH),
    .KW   (KW)
  ) u_step (
    .ra       (ra_q),
    .rb       (rb_q),
    .k        (k_q),
    .ra_next_c(step_ra),
    .rb_next_c(step_rb),
    .k_next_c (step_k),
    .finish_c (step_fin),
    .result_c (step_res)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    zlat_d    = zlat_q;
    done_d    = 1'b0;
    gcd_d     = gcd_q;
    cycles_d  = cycles_q;
    zero_in_d = zero_in_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          k_d     = '0;
          cnt_d   = '0;
          zlat_d  = (a == '0) || (b == '0);
          state_d = CALC;
        end
      end
      CALC: begin
        ra_d = step_ra;
        rb_d = step_rb;
        k_d  = step_k;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
        if (step_fin) begin
          res_d   = step_res;
          state_d = FINISH;
        end
      end
      FINISH: begin
        done_d    = 1'b1;
        gcd_d     = res_q;
        cycles_d  = cnt_q;
        zero_in_d = zlat_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CALC) || (state_d == FINISH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ra_q      <= '0;
      rb_q      <= '0;
      k_q       <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      zlat_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      gcd_q     <= '0;
      cycles_q  <= '0;
      zero_in_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      zlat_q    <= zlat_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      gcd_q     <= gcd_d;
      cycles_q  <= cycles_d;
      zero_in_q <= zero_in_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign gcd     = gcd_q;
  assign cycles  = cycles_q;
  assign zero_in = zero_in_q;

endmodule
